// File: rtl/dif_butterfly_pkg.sv
`default_nettype none
// ============================================================================
// dif_butterfly_pkg : pipeline depths and mode encoding shared by the DIF datapath
// Rev 1.0
// ============================================================================
package dif_butterfly_pkg;

    localparam int INTMUL_DELAY = 2;
    localparam int MODRED_DELAY = 2;
    localparam int MODMUL_DELAY = INTMUL_DELAY + MODRED_DELAY;
    localparam int BFLY_LATENCY = 1 + MODMUL_DELAY;

    typedef enum logic {
        MODE_GS  = 1'b0,
        MODE_MUL = 1'b1
    } bfly_mode_e;

endpackage
`default_nettype wire

// File: rtl/dif_butterfly_modmul.sv
`default_nettype none
// ============================================================================
// modmul : pipelined integer multiply followed by pipelined reduction mod q
// Rev 1.0
// ============================================================================
module modmul
    import dif_butterfly_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_q,
    output logic [WIDTH-1:0] o_res
);

    logic [2*WIDTH-1:0] r_prod [INTMUL_DELAY];
    logic [WIDTH-1:0]   r_qm   [INTMUL_DELAY];
    logic [WIDTH-1:0]   r_red  [MODRED_DELAY];

    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_q_ext;
    logic [WIDTH-1:0]   w_rem;

    assign w_a_ext = {{WIDTH{1'b0}}, i_a};
    assign w_b_ext = {{WIDTH{1'b0}}, i_b};
    assign w_q_ext = {{WIDTH{1'b0}}, r_qm[INTMUL_DELAY-1]};
    // Invalid slots may carry q=0; force a defined remainder instead of dividing by zero.
    assign w_rem   = (r_qm[INTMUL_DELAY-1] == '0) ? '0
                   : WIDTH'(r_prod[INTMUL_DELAY-1] % w_q_ext);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < INTMUL_DELAY; i++) begin
                r_prod[i] <= '0;
                r_qm[i]   <= '0;
            end
            for (int i = 0; i < MODRED_DELAY; i++) begin
                r_red[i] <= '0;
            end
        end else begin
            r_prod[0] <= w_a_ext * w_b_ext;
            r_qm[0]   <= i_q;
            for (int i = 1; i < INTMUL_DELAY; i++) begin
                r_prod[i] <= r_prod[i-1];
                r_qm[i]   <= r_qm[i-1];
            end
            r_red[0] <= w_rem;
            for (int i = 1; i < MODRED_DELAY; i++) begin
                r_red[i] <= r_red[i-1];
            end
        end
    end

    assign o_res = r_red[MODRED_DELAY-1];

endmodule
`default_nettype wire

// File: rtl/dif_butterfly.sv
`default_nettype none
// ============================================================================
// dif_butterfly : Gentleman-Sande NTT butterfly / modular multiplier, fully pipelined
// Rev 1.0
// ============================================================================
module dif_butterfly
    import dif_butterfly_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] W,
    input  logic [WIDTH-1:0] modulus,
    output logic             out_valid,
    output logic [WIDTH-1:0] A_out,
    output logic [WIDTH-1:0] B_out
);

    localparam int L = BFLY_LATENCY;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_sum_red;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_prod;

    logic [L-1:0]     r_vld;
    logic [L-1:0]     r_mode_dly;
    logic [WIDTH-1:0] r_sum_dly [L];
    logic [WIDTH-1:0] r_diff;
    logic [WIDTH-1:0] r_w;
    logic [WIDTH-1:0] r_q;

    // Sum needs the extra bit: A+B can reach 2q-2 which exceeds WIDTH bits for wide q.
    assign w_sum     = {1'b0, A} + {1'b0, B};
    assign w_sum_red = (w_sum >= {1'b0, modulus}) ? (w_sum - {1'b0, modulus}) : w_sum;
    assign w_diff    = (A < B) ? (A - B + modulus) : (A - B);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld      <= '0;
            r_mode_dly <= '0;
            r_diff     <= '0;
            r_w        <= '0;
            r_q        <= '0;
            for (int i = 0; i < L; i++) begin
                r_sum_dly[i] <= '0;
            end
        end else begin
            r_vld      <= {r_vld[L-2:0], in_valid};
            r_mode_dly <= {r_mode_dly[L-2:0], mode};
            r_diff     <= (mode == MODE_MUL) ? B : w_diff;
            r_w        <= W;
            r_q        <= modulus;
            r_sum_dly[0] <= w_sum_red[WIDTH-1:0];
            for (int i = 1; i < L; i++) begin
                r_sum_dly[i] <= r_sum_dly[i-1];
            end
        end
    end

    modmul #(
        .WIDTH (WIDTH)
    ) u_modmul (
        .clk   (clk),
        .reset (reset),
        .i_a   (r_diff),
        .i_b   (r_w),
        .i_q   (r_q),
        .o_res (w_prod)
    );

    assign out_valid = r_vld[L-1];
    assign A_out = !r_vld[L-1]                  ? '0
                 : (r_mode_dly[L-1] == MODE_MUL) ? w_prod
                 :                                 r_sum_dly[L-1];
    assign B_out = (!r_vld[L-1] || (r_mode_dly[L-1] == MODE_MUL)) ? '0 : w_prod;

endmodule
`default_nettype wire

// File: tb/tb_dif_butterfly.sv
`default_nettype none
// ============================================================================
// tb_dif_butterfly : scoreboard bench with directed and randomized butterflies
// Rev 1.0
// ============================================================================
module tb_dif_butterfly;
    import dif_butterfly_pkg::*;

    localparam int WIDTH = 32;
    localparam int LAT   = BFLY_LATENCY;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               cyc;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] W;
    logic [WIDTH-1:0] modulus;
    logic             out_valid;
    logic [WIDTH-1:0] A_out;
    logic [WIDTH-1:0] B_out;

    exp_t sb[$];
    int   n_vec;
    int   n_err;
    int   cyc;
    logic mon_en;

    dif_butterfly #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .mode      (mode),
        .A         (A),
        .B         (B),
        .W         (W),
        .modulus   (modulus),
        .out_valid (out_valid),
        .A_out     (A_out),
        .B_out     (B_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain modular arithmetic on 64-bit integers.
    function automatic void ref_model(input logic m, input longint unsigned a, input longint unsigned b,
                                      input longint unsigned w, input longint unsigned q,
                                      output logic [WIDTH-1:0] ea, output logic [WIDTH-1:0] eb);
        longint unsigned d;
        if (m) begin
            ea = WIDTH'((b * w) % q);
            eb = '0;
        end else begin
            d  = (a + q - b) % q;
            ea = WIDTH'((a + b) % q);
            eb = WIDTH'((d * w) % q);
        end
    endfunction

    task automatic issue(input logic m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] q,
                         input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb);
        exp_t e;
        in_valid = 1'b1;
        mode     = m;
        A        = a;
        B        = b;
        W        = w;
        modulus  = q;
        e.a   = ea;
        e.b   = eb;
        e.cyc = cyc + LAT;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic issue_model(input logic m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] ea;
        logic [WIDTH-1:0] eb;
        ref_model(m, a, b, w, q, ea, eb);
        issue(m, a, b, w, q, ea, eb);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every valid output pops the scoreboard; idle cycles must read zero.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_valid: got out_valid=1 A_out=%0d B_out=%0d, expected no output", A_out, B_out);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (A_out !== e.a || B_out !== e.b || cyc != e.cyc) begin
                        n_err++;
                        $display("FAIL result: got A_out=%0d B_out=%0d at cycle %0d, expected A_out=%0d B_out=%0d at cycle %0d",
                                 A_out, B_out, cyc, e.a, e.b, e.cyc);
                    end
                end
            end else begin
                n_vec++;
                if (A_out !== '0 || B_out !== '0) begin
                    n_err++;
                    $display("FAIL idle_zero: got A_out=%0d B_out=%0d, expected 0 0", A_out, B_out);
                end
                if (sb.size() != 0 && cyc > sb[0].cyc) begin
                    n_err++;
                    $display("FAIL missing_output: expected result due at cycle %0d, now %0d", sb[0].cyc, cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    int unsigned primes [6] = '{32'd7681, 32'd12289, 32'd3329, 32'd4244570881, 32'd2013265921, 32'd65537};

    initial begin
        logic [WIDTH-1:0] q, a, b, w;
        logic             m;
        int               waited;
        n_vec    = 0;
        n_err    = 0;
        cyc      = 0;
        mon_en   = 1'b0;
        reset    = 1'b0;
        in_valid = 1'b0;
        mode     = 1'b0;
        A        = '0;
        B        = '0;
        W        = '0;
        modulus  = 32'd7681;

        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || A_out !== '0 || B_out !== '0) begin
            n_err++;
            $display("FAIL reset_state: got out_valid=%0b A_out=%0d B_out=%0d, expected 0 0 0", out_valid, A_out, B_out);
        end
        reset  = 1'b1;
        mon_en = 1'b1;
        idle(2);

        // Directed cases back to back, alternating mode, expected values fixed by hand.
        issue(1'b0, 32'd100,        32'd50,         32'd2,    32'd7681,       32'd150,        32'd100);
        issue(1'b1, 32'hBAD,        32'd1234,       32'd5678, 32'd7681,       32'd1580,       32'd0);
        issue(1'b0, 32'd7000,       32'd1000,       32'd1,    32'd7681,       32'd319,        32'd6000);
        issue(1'b1, 32'd0,          32'd1234,       32'd5678, 32'd7681,       32'd1580,       32'd0);
        issue(1'b0, 32'd10,         32'd20,         32'd3,    32'd7681,       32'd30,         32'd7651);
        issue(1'b1, 32'd5,          32'd0,          32'd77,   32'd7681,       32'd0,          32'd0);
        issue(1'b0, 32'd4244570880, 32'd4244570880, 32'd1,    32'd4244570881, 32'd4244570879, 32'd0);
        idle(LAT + 2);

        // Boundary operands through the model.
        issue_model(1'b0, 32'd0,    32'd0,    32'd0,    32'd12289);
        issue_model(1'b0, 32'd0,    32'd12288, 32'd1,   32'd12289);
        issue_model(1'b0, 32'd3328, 32'd0,    32'd3328, 32'd3329);
        issue_model(1'b1, 32'd1,    32'd3328, 32'd3328, 32'd3329);
        issue_model(1'b0, 32'd2013265920, 32'd1, 32'd2013265920, 32'd2013265921);

        // Random stream with per-cycle modulus and mode changes.
        for (int i = 0; i < 200; i++) begin
            q = primes[$urandom_range(0, 5)];
            a = $urandom % q;
            b = $urandom % q;
            w = $urandom % q;
            m = 1'($urandom_range(0, 1));
            issue_model(m, a, b, w, q);
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        idle(LAT + 2);

        // Reset with LAT-1 operations in flight: none may surface afterwards.
        for (int i = 0; i < LAT - 1; i++) begin
            issue_model(1'b0, 32'd100 + i, 32'd50, 32'd2, 32'd7681);
        end
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || A_out !== '0 || B_out !== '0) begin
            n_err++;
            $display("FAIL async_reset: got out_valid=%0b A_out=%0d B_out=%0d, expected 0 0 0", out_valid, A_out, B_out);
        end
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(LAT + 3);
        issue_model(1'b0, 32'd7000, 32'd1000, 32'd5, 32'd7681);
        idle(LAT + 3);

        waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d results still pending, expected 0", sb.size());
        end
        #1;
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dif_butterfly.md
DIF_BUTTERFLY -- requirements
Module: dif_butterfly

Interface
REQ-001 Parameter WIDTH, default 32, coefficient/modulus bit width.
REQ-002 Latency constants INTMUL_DELAY and MODRED_DELAY, from defines.v: integer-multiply and modular-reduction pipeline depths.
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  A, B, W, modulus and mode are sampled this cycle.
REQ-006 mode  input  1  0 = Gentleman-Sande butterfly; 1 = plain modular multiply.
REQ-007 A  input  WIDTH  upper operand, less than modulus.
REQ-008 B  input  WIDTH  lower operand, less than modulus.
REQ-009 W  input  WIDTH  twiddle factor, less than modulus.
REQ-010 modulus  input  WIDTH  prime q, with 2 < q < 2^WIDTH.
REQ-011 out_valid  output  1  A_out and B_out carry a result this cycle.
REQ-012 A_out  output  WIDTH  upper result.
REQ-013 B_out  output  WIDTH  lower result.

Function
REQ-014 When mode=0, the block SHALL produce A_out = (A+B) mod q and B_out = ((A-B) mod q)*W mod q. This is the inverse-NTT counterpart of the DIT butterfly.
REQ-015 When mode=1, the block SHALL produce A_out = B*W mod q and B_out = 0, and SHALL ignore A.
REQ-016 Stage 0 (one registered cycle) SHALL compute the sum and difference:
- The sum uses WIDTH+1 bits; subtract q once if sum >= q.
- The difference adds q if A < B.
- In mode=1 the difference register SHALL load B instead.
REQ-017 Stages 1..L-1 SHALL multiply the registered difference by W through the modular multiplier. W, q and mode SHALL be registered alongside their operands.
REQ-018 The registered sum and mode SHALL be carried through a delay line, so that A_out aligns with B_out in the same cycle.
REQ-019 Latency SHALL be exactly L = 1 + INTMUL_DELAY + MODRED_DELAY cycles from the in_valid edge to the out_valid edge.
REQ-020 The block SHALL be fully pipelined:
- It accepts one operation per cycle with no backpressure.
- Butterfly and multiply operations may be interleaved on consecutive cycles.
REQ-021 out_valid SHALL be in_valid delayed by L cycles.
REQ-022 When out_valid=0, A_out and B_out SHALL hold 0; data registers of invalid slots are don't-care internally.
REQ-023 Results SHALL be fully reduced to the range [0, q-1] for all inputs that satisfy REQ-007..REQ-010, including A=B, A=0, B=0, W=0 and W=1.
REQ-024 The modulus may change every cycle. Each operation SHALL use the q sampled with it.

Reset
REQ-025 While reset=0, every valid bit, A_out, B_out and out_valid SHALL be 0, asynchronously.
REQ-026 Operations in flight when reset asserts SHALL be discarded; none SHALL emerge after reset is released.
REQ-027 The first in_valid after reset deasserts SHALL produce out_valid exactly L cycles later.

Structure
REQ-028 INTMUL_DELAY, MODRED_DELAY and derived latency macros SHALL live in the shared defines.v. No other shared typedefs are needed.
REQ-029 One sub-module, modmul, SHALL provide the pipelined integer multiply plus modular reduction with latency INTMUL_DELAY + MODRED_DELAY. It SHALL be reused unchanged from the DIT datapath.
REQ-030 The add/sub stage, valid shift register and sum delay line SHALL be implemented in dif_butterfly itself.

Verification
REQ-031 q=7681, mode=0, A=100, B=50, W=2 -> after L cycles A_out=150, B_out=100, out_valid=1.
REQ-032 Sum wrap and negative difference, q=7681, mode=0:
- A=7000, B=1000, W=1 -> A_out=319, B_out=6000.
- A=10, B=20, W=3 -> A_out=30, B_out=7651.
REQ-033 q=7681, mode=1, A=0xBAD, B=1234, W=5678 -> A_out=1580, B_out=0.
REQ-034 Wide-modulus edge, q=4244570881, mode=0, A=B=4244570880, W=1 -> A_out=4244570879, B_out=0.
REQ-035 Streaming: issue the cases of REQ-031..REQ-034 on consecutive cycles, alternating mode -> results on consecutive cycles in issue order, with out_valid high continuously.
REQ-036 Reset mid-stream: assert reset with L-1 operations in flight, release it, issue one operation -> no stale out_valid, then exactly one correct result L cycles after issue.
